// File: rtl/opl3_timer_status.sv
// OPL3 timer control/status stage: decodes the timer control register into
// start levels and masks, and keeps the sticky overflow flags behind status/irq_n.
module opl3_timer_status #(
  parameter logic [8:0] TIMER_CTRL_ADDR = 9'h004,
  parameter int         DATA_WIDTH      = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  wr,
  input  logic [8:0]            wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  timer1_overflow_pulse,
  input  logic                  timer2_overflow_pulse,
  output logic                  start_timer1,
  output logic                  start_timer2,
  output logic [DATA_WIDTH-1:0] status,
  output logic                  irq_n
);

  logic st1_q, st2_q, mt1_q, mt2_q, ft1_q, ft2_q;
  logic st1_d, st2_d, mt1_d, mt2_d, ft1_d, ft2_d;
  logic ctrl_wr, rst_flags, load_ctrl;

  assign ctrl_wr   = wr && (wr_addr == TIMER_CTRL_ADDR);
  assign rst_flags = ctrl_wr && wr_data[7];
  assign load_ctrl = ctrl_wr && !wr_data[7];

  // Bits 4:2 of the control byte are reserved and intentionally dropped.
  logic unused_wr_data;
  assign unused_wr_data = ^wr_data[4:2];

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    st1_d = st1_q;
    st2_d = st2_q;
    mt1_d = mt1_q;
    mt2_d = mt2_q;
    // Masks are the pre-write register values, so a same-cycle write to the
    // mask never changes whether this cycle's pulse is captured.
    ft1_d = ft1_q | (timer1_overflow_pulse & ~mt1_q);
    ft2_d = ft2_q | (timer2_overflow_pulse & ~mt2_q);
    if (load_ctrl) begin
      mt1_d = wr_data[6];
      mt2_d = wr_data[5];
      st2_d = wr_data[1];
      st1_d = wr_data[0];
    end
    if (rst_flags) begin
      ft1_d = 1'b0;
      ft2_d = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st1_q <= 1'b0;
      st2_q <= 1'b0;
      mt1_q <= 1'b0;
      mt2_q <= 1'b0;
      ft1_q <= 1'b0;
      ft2_q <= 1'b0;
    end else begin
      st1_q <= st1_d;
      st2_q <= st2_d;
      mt1_q <= mt1_d;
      mt2_q <= mt2_d;
      ft1_q <= ft1_d;
      ft2_q <= ft2_d;
    end
  end

  assign start_timer1 = st1_q;
  assign start_timer2 = st2_q;
  assign irq_n        = ~(ft1_q | ft2_q);

  always_comb begin
    status                   = '0;
    status[DATA_WIDTH-1]     = ft1_q | ft2_q;
    status[DATA_WIDTH-2]     = ft1_q;
    status[DATA_WIDTH-3]     = ft2_q;
  end

endmodule

// File: tb/tb_opl3_timer_status.sv
// Scoreboard bench for opl3_timer_status: stimulus queues hand-computed
// expected outputs, a negedge monitor pops and compares them.
module tb_opl3_timer_status;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       wr = 1'b0;
  logic [8:0] wr_addr = '0;
  logic [7:0] wr_data = '0;
  logic       p1 = 1'b0, p2 = 1'b0;
  logic       start_timer1, start_timer2, irq_n;
  logic [7:0] status;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    string      name;
    logic       st1;
    logic       st2;
    logic [7:0] stat;
    logic       irq_n;
  } exp_t;

  exp_t exp_q[$];

  opl3_timer_status #(.TIMER_CTRL_ADDR(9'h004), .DATA_WIDTH(8)) dut (
    .clk                   (clk),
    .reset_n               (reset_n),
    .wr                    (wr),
    .wr_addr               (wr_addr),
    .wr_data               (wr_data),
    .timer1_overflow_pulse (p1),
    .timer2_overflow_pulse (p2),
    .start_timer1          (start_timer1),
    .start_timer2          (start_timer2),
    .status                (status),
    .irq_n                 (irq_n)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Monitor: outputs are sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check({e.name, ".start1"}, {7'b0, start_timer1}, {7'b0, e.st1});
      check({e.name, ".start2"}, {7'b0, start_timer2}, {7'b0, e.st2});
      check({e.name, ".status"}, status, e.stat);
      check({e.name, ".irq_n"},  {7'b0, irq_n}, {7'b0, e.irq_n});
    end
  end

  task automatic expect_out(input string nm, input logic s1, input logic s2,
                            input logic [7:0] st, input logic irq);
    exp_t e;
    e.name = nm; e.st1 = s1; e.st2 = s2; e.stat = st; e.irq_n = irq;
    exp_q.push_back(e);
  endtask

  // One clock cycle of stimulus; expected outputs after the edge are queued.
  task automatic step(input string nm, input logic w, input logic [8:0] a,
                      input logic [7:0] d, input logic t1, input logic t2,
                      input logic s1, input logic s2, input logic [7:0] st,
                      input logic irq);
    wr = w; wr_addr = a; wr_data = d; p1 = t1; p2 = t2;
    @(posedge clk);
    #1;
    wr = 1'b0; wr_addr = '0; wr_data = '0; p1 = 1'b0; p2 = 1'b0;
    expect_out(nm, s1, s2, st, irq);
    @(negedge clk);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    expect_out("reset_hold", 0, 0, 8'h00, 1);
    @(negedge clk);
    reset_n = 1'b1;
    step("idle_after_reset", 0, 9'h000, 8'h00, 0, 0, 0, 0, 8'h00, 1);

    // Start and flag
    step("start1",      1, 9'h004, 8'h01, 0, 0, 1, 0, 8'h00, 1);
    step("ovf1",        0, 9'h000, 8'h00, 1, 0, 1, 0, 8'hC0, 0);
    step("rst_flags",   1, 9'h004, 8'h80, 0, 0, 1, 0, 8'h00, 1);
    step("ovf1_again",  0, 9'h000, 8'h00, 1, 0, 1, 0, 8'hC0, 0);

    // Asynchronous reset mid-run with ST1=1, FT1=1
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1 expect_out("async_reset", 0, 0, 8'h00, 1);
    @(negedge clk);
    step("wr_in_reset", 1, 9'h004, 8'h03, 1, 1, 0, 0, 8'h00, 1);
    reset_n = 1'b1;
    step("post_reset",  0, 9'h000, 8'h00, 0, 0, 0, 0, 8'h00, 1);

    // Mask
    step("mask2_start2", 1, 9'h004, 8'h22, 0, 0, 0, 1, 8'h00, 1);
    step("ovf2_masked",  0, 9'h000, 8'h00, 0, 1, 0, 1, 8'h00, 1);
    step("unmask2",      1, 9'h004, 8'h02, 0, 0, 0, 1, 8'h00, 1);
    step("ovf2",         0, 9'h000, 8'h00, 0, 1, 0, 1, 8'hA0, 0);
    step("mask_keeps",   1, 9'h004, 8'h22, 0, 0, 0, 1, 8'hA0, 0);

    // Simultaneous events
    step("unmask_all",   1, 9'h004, 8'h00, 0, 0, 0, 0, 8'hA0, 0);
    step("ovf1_st0",     0, 9'h000, 8'h00, 1, 0, 0, 0, 8'hE0, 0);
    step("rst_vs_ovf",   1, 9'h004, 8'h80, 1, 1, 0, 0, 8'h00, 1);
    step("both_ovf",     0, 9'h000, 8'h00, 1, 1, 0, 0, 8'hE0, 0);
    step("rst_both",     1, 9'h004, 8'h80, 0, 0, 0, 0, 8'h00, 1);

    // Address decode, back-to-back writes
    step("bank1_alias",  1, 9'h104, 8'h03, 0, 0, 0, 0, 8'h00, 1);
    step("addr_005",     1, 9'h005, 8'h03, 0, 0, 0, 0, 8'h00, 1);
    step("start_both",   1, 9'h004, 8'h03, 0, 0, 1, 1, 8'h00, 1);
    step("rst_keeps_st", 1, 9'h004, 8'h80, 0, 0, 1, 1, 8'h00, 1);

    // Same-cycle mask writes
    step("set_mask_ovf", 1, 9'h004, 8'h40, 1, 0, 0, 0, 8'hC0, 0);
    step("clr_flags",    1, 9'h004, 8'h80, 0, 0, 0, 0, 8'h00, 1);
    step("ovf1_masked",  0, 9'h000, 8'h00, 1, 0, 0, 0, 8'h00, 1);
    step("clr_mask_ovf", 1, 9'h004, 8'h00, 1, 0, 0, 0, 8'h00, 1);
    step("ovf1_unmask",  0, 9'h000, 8'h00, 1, 0, 0, 0, 8'hC0, 0);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end
    @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
